ov_seq_ctrl: RTL and testbench
==============================

Name: ov_seq_ctrl

Overview:
Digital sequencer for the AVDD overvoltage detector. It powers up the detector, applies the trip code and bias-source select, and blanks the comparator output while the analog settles. It synchronises and debounces the raw comparator output (ovout) into a clean flag, a sticky fault bit and a rising-edge interrupt pulse. It sits in the dvdd domain between the register file and the detector's ena/otrip/isrc_sel inputs.

Parameters:
SETTLE_CYCLES, 64, cycles from ena rising (or an isrc_sel change) until the comparator output is trusted
BLANK_CYCLES, 16, cycles ovout is ignored after the applied trip code changes
DEBOUNCE_CYCLES, 8, consecutive synchronised cycles required to change ov_flag
CNT_W, 8, width of the shared settle/blank counter and the debounce counter; must hold max(SETTLE_CYCLES, BLANK_CYCLES, DEBOUNCE_CYCLES)

Ports:
clk  in  1  dvdd-domain clock
resetb  in  1  asynchronous active-low reset
en_req  in  1  software enable request
otrip_req  in  4  requested trip code
isrc_sel_req  in  1  requested bias source (0 internal, 1 external ibg_200n)
ovout_raw  in  1  asynchronous comparator output
fault_clr  in  1  single-cycle clear for ov_fault
ena  out  1  detector enable
otrip  out  4  applied trip code
isrc_sel  out  1  applied bias select
ready  out  1  monitoring is active and ov_flag is being updated
ov_flag  out  1  debounced overvoltage status
ov_fault  out  1  sticky overvoltage latch
ov_irq  out  1  one-cycle pulse on an ov_flag 0->1 transition
state  out  2  current FSM state (IDLE=0, SETTLE=1, ARMED=2, BLANK=3)

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; counters 0; synchroniser flops 0.
- ovout_raw passes through a 2-flop synchroniser to give ov_sync. Only ov_sync is used.
- IDLE:
  - ena=0, ready=0, ov_flag=0, debounce counter held at 0.
  - On en_req=1 at edge k: go to SETTLE; ena=1, otrip<=otrip_req and isrc_sel<=isrc_sel_req, all registered at edge k; counter loaded with 0.
- SETTLE:
  - Counter increments each cycle.
  - When counter == SETTLE_CYCLES-1: go to ARMED; ready=1 after edge k+SETTLE_CYCLES.
  - ov_sync is ignored and ov_flag holds.
- ARMED, debounce:
  - If ov_sync != ov_flag, the debounce counter increments; otherwise it clears.
  - When the count reaches DEBOUNCE_CYCLES, ov_flag toggles and the counter clears.
  - A stable raw change is therefore visible on ov_flag DEBOUNCE_CYCLES+2 edges after it occurs.
  - Any glitch shorter than DEBOUNCE_CYCLES leaves ov_flag unchanged.
- ov_fault is set when ov_flag rises.
  - fault_clr clears it.
  - If set and clear occur in the same cycle, set wins.
  - ov_fault survives en_req=0 and is cleared only by reset or fault_clr.
- ov_irq is high for exactly one cycle, coincident with ov_flag rising.
- ARMED, otrip_req != otrip:
  - otrip<=otrip_req; go to BLANK; ready=0.
  - Debounce counter cleared; ov_flag held; blank counter loaded with 0.
- BLANK:
  - Counter increments; after BLANK_CYCLES cycles, return to ARMED with ready=1.
  - If otrip_req changes again, otrip is updated and the blank counter restarts at 0.
- isrc_sel_req != isrc_sel in ARMED or BLANK:
  - isrc_sel updated; go to SETTLE, counter 0; ready=0; ov_flag held.
  - This takes priority over an otrip change in the same cycle; both values are applied.
- isrc_sel_req change in SETTLE: isrc_sel updated and the settle counter restarts.
- otrip_req change in SETTLE: otrip updated; no restart, because settle already covers blanking.
- en_req=0 in any state: next edge -> IDLE; ena=0, ready=0, ov_flag=0, no ov_irq.
  - otrip and isrc_sel hold their last values.
  - en_req=0 overrides all other transitions.
- Counters saturate and never wrap.
- All outputs are registered.

Test Plan:
- Reset, then en_req=1 at cycle 10 -> ena=1 at cycle 11; state=SETTLE; ready=1 exactly 64 cycles later; ov_flag=0.
- In ARMED, drive ovout_raw high and hold -> ov_flag=1 and ov_irq pulses for one cycle exactly 10 edges later; ov_fault=1. Then drop ovout_raw -> ov_flag=0 after 10 edges; ov_fault stays 1.
- In ARMED, drive ovout_raw 7-cycle high pulses separated by 1-cycle lows -> ov_flag never asserts and ov_irq stays 0.
- Change otrip_req 5->9 in ARMED -> otrip=9 next edge; ready=0 for 16 cycles. Raw ovout pulses during blanking are ignored. Change otrip_req to 3 mid-blank -> blank restarts, giving 16 cycles from the last change.
- Toggle isrc_sel_req in ARMED with ov_flag=1 -> state=SETTLE; ready=0 for 64 cycles; ov_flag held at 1. Same-cycle otrip change -> both applied, and state enters SETTLE, not BLANK.
- Assert fault_clr in the same cycle ov_flag rises -> ov_fault=1. fault_clr one cycle later -> 0. en_req=0 mid-SETTLE -> IDLE; ena=0; counters cleared. Assert resetb low mid-BLANK -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ov_seq_ctrl.sv
// Sequencer for the AVDD overvoltage detector: power-up/settle, trip-code blanking,
// and synchronised, debounced comparator status with a sticky fault and rising-edge irq.
module ov_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES   = 64,
    parameter int unsigned BLANK_CYCLES    = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       en_req,
    input  logic [3:0] otrip_req,
    input  logic       isrc_sel_req,
    input  logic       ovout_raw,
    input  logic       fault_clr,
    output logic       ena,
    output logic [3:0] otrip,
    output logic       isrc_sel,
    output logic       ready,
    output logic       ov_flag,
    output logic       ov_fault,
    output logic       ov_irq,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_ARMED  = 2'd2;
    localparam logic [1:0] ST_BLANK  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             ov_sync_r;
    logic [1:0]       state_r,  state_nxt_s;
    logic             ena_r,    ena_nxt_s;
    logic [3:0]       otrip_r,  otrip_nxt_s;
    logic             isrc_r,   isrc_nxt_s;
    logic             ready_r,  ready_nxt_s;
    logic             flag_r,   flag_nxt_s;
    logic             fault_r,  fault_nxt_s;
    logic             irq_r,    irq_nxt_s;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
    logic [CNT_W-1:0] dcnt_r,   dcnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] dcnt_inc_s;
    logic             otrip_chg_s;
    logic             isrc_chg_s;
    logic             rise_s;

    // Saturating increments so neither counter can ever wrap.
    assign cnt_inc_s   = (cnt_r  == CNT_MAX) ? cnt_r  : cnt_r  + CNT_ONE;
    assign dcnt_inc_s  = (dcnt_r == CNT_MAX) ? dcnt_r : dcnt_r + CNT_ONE;
    assign otrip_chg_s = (otrip_req != otrip_r);
    assign isrc_chg_s  = (isrc_sel_req != isrc_r);

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync1_r   <= 1'b0;
            ov_sync_r <= 1'b0;
        end else begin
            sync1_r   <= ovout_raw;
            ov_sync_r <= sync1_r;
        end
    end

    // Sequencer next state: enable drop first, then bias change, then trip change.
    always_comb begin
        state_nxt_s = state_r;
        ena_nxt_s   = ena_r;
        otrip_nxt_s = otrip_r;
        isrc_nxt_s  = isrc_r;
        ready_nxt_s = ready_r;
        flag_nxt_s  = flag_r;
        cnt_nxt_s   = cnt_r;
        dcnt_nxt_s  = CNT_ZERO;
        if (!en_req) begin
            state_nxt_s = ST_IDLE;
            ena_nxt_s   = 1'b0;
            ready_nxt_s = 1'b0;
            flag_nxt_s  = 1'b0;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_SETTLE;
                    ena_nxt_s   = 1'b1;
                    otrip_nxt_s = otrip_req;
                    isrc_nxt_s  = isrc_sel_req;
                    ready_nxt_s = 1'b0;
                    cnt_nxt_s   = CNT_ZERO;
                end
                ST_SETTLE: begin
                    // Settling already covers blanking, so a trip change does not restart it.
                    if (otrip_chg_s) begin
                        otrip_nxt_s = otrip_req;
                    end else begin
                        otrip_nxt_s = otrip_r;
                    end
                    if (isrc_chg_s) begin
                        isrc_nxt_s = isrc_sel_req;
                        cnt_nxt_s  = CNT_ZERO;
                    end else if (cnt_r >= SETTLE_LAST) begin
                        state_nxt_s = ST_ARMED;
                        ready_nxt_s = 1'b1;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                ST_ARMED: begin
                    if (isrc_chg_s) begin
                        state_nxt_s = ST_SETTLE;
                        isrc_nxt_s  = isrc_sel_req;
                        otrip_nxt_s = otrip_req;
                        ready_nxt_s = 1'b0;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (otrip_chg_s) begin
                        state_nxt_s = ST_BLANK;
                        otrip_nxt_s = otrip_req;
                        ready_nxt_s = 1'b0;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (ov_sync_r != flag_r) begin
                        if (dcnt_r >= DEB_LAST) begin
                            flag_nxt_s = ~flag_r;
                            dcnt_nxt_s = CNT_ZERO;
                        end else begin
                            dcnt_nxt_s = dcnt_inc_s;
                        end
                    end else begin
                        dcnt_nxt_s = CNT_ZERO;
                    end
                end
                ST_BLANK: begin
                    if (isrc_chg_s) begin
                        state_nxt_s = ST_SETTLE;
                        isrc_nxt_s  = isrc_sel_req;
                        otrip_nxt_s = otrip_req;
                        ready_nxt_s = 1'b0;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (otrip_chg_s) begin
                        otrip_nxt_s = otrip_req;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r >= BLANK_LAST) begin
                        state_nxt_s = ST_ARMED;
                        ready_nxt_s = 1'b1;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    ena_nxt_s   = 1'b0;
                    ready_nxt_s = 1'b0;
                    flag_nxt_s  = 1'b0;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Rising edge of the debounced flag drives the irq pulse and sets the sticky fault (set beats clear).
    always_comb begin
        rise_s      = flag_nxt_s & ~flag_r;
        irq_nxt_s   = rise_s;
        fault_nxt_s = rise_s | (fault_r & ~fault_clr);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r <= ST_IDLE;
            ena_r   <= 1'b0;
            otrip_r <= 4'd0;
            isrc_r  <= 1'b0;
            ready_r <= 1'b0;
            flag_r  <= 1'b0;
            fault_r <= 1'b0;
            irq_r   <= 1'b0;
            cnt_r   <= CNT_ZERO;
            dcnt_r  <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            ena_r   <= ena_nxt_s;
            otrip_r <= otrip_nxt_s;
            isrc_r  <= isrc_nxt_s;
            ready_r <= ready_nxt_s;
            flag_r  <= flag_nxt_s;
            fault_r <= fault_nxt_s;
            irq_r   <= irq_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dcnt_r  <= dcnt_nxt_s;
        end
    end

    assign state    = state_r;
    assign ena      = ena_r;
    assign otrip    = otrip_r;
    assign isrc_sel = isrc_r;
    assign ready    = ready_r;
    assign ov_flag  = flag_r;
    assign ov_fault = fault_r;
    assign ov_irq   = irq_r;

endmodule

// File: tb/tb_ov_seq_ctrl.sv
// Bench for ov_seq_ctrl: directed vector table, hand-written corner sequences,
// and randomized stimulus compared every cycle against a timestamp/window reference model.
module tb_ov_seq_ctrl;

    localparam int SETTLE = 64;
    localparam int BLANK  = 16;
    localparam int DEB    = 8;

    logic       clk = 1'b0;
    logic       resetb;
    logic       en_req;
    logic [3:0] otrip_req;
    logic       isrc_sel_req;
    logic       ovout_raw;
    logic       fault_clr;
    logic       ena;
    logic [3:0] otrip;
    logic       isrc_sel;
    logic       ready;
    logic       ov_flag;
    logic       ov_fault;
    logic       ov_irq;
    logic [1:0] state;

    ov_seq_ctrl #(
        .SETTLE_CYCLES(SETTLE), .BLANK_CYCLES(BLANK), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)
    ) dut (
        .clk(clk), .resetb(resetb), .en_req(en_req), .otrip_req(otrip_req),
        .isrc_sel_req(isrc_sel_req), .ovout_raw(ovout_raw), .fault_clr(fault_clr),
        .ena(ena), .otrip(otrip), .isrc_sel(isrc_sel), .ready(ready), .ov_flag(ov_flag),
        .ov_fault(ov_fault), .ov_irq(ov_irq), .state(state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: modes, deadline timestamps and a window of mismatch history.
    int         m_mode;
    int         m_edge;
    int         m_deadline;
    logic       m_ena, m_isrc, m_ready, m_flag, m_fault, m_irq;
    logic [3:0] m_otrip;
    logic       m_q1, m_q2;
    bit         m_win[$];

    typedef struct {
        logic       en;
        logic [3:0] ot;
        logic       is;
        logic       raw;
        logic       clr;
        int         cyc;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [11:0] dut_vec();
        return {state, ena, otrip, isrc_sel, ready, ov_flag, ov_fault, ov_irq};
    endfunction

    function automatic logic [11:0] model_vec();
        logic [1:0] st;
        st = 2'(m_mode);
        return {st, m_ena, m_otrip, m_isrc, m_ready, m_flag, m_fault, m_irq};
    endfunction

    function automatic vec_t mk(logic en, logic [3:0] ot, logic is, logic raw, logic clr, int cyc,
                                logic [1:0] st, logic e_ena, logic [3:0] e_ot, logic e_is,
                                logic rdy, logic fl, logic fa, logic irq);
        vec_t v;
        v.en = en; v.ot = ot; v.is = is; v.raw = raw; v.clr = clr; v.cyc = cyc;
        v.exp = {st, e_ena, e_ot, e_is, rdy, fl, fa, irq};
        return v;
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {st,ena,otrip,isrc,rdy,flag,fault,irq}=%b expected %b",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_edge = 0; m_deadline = 0;
        m_ena = 1'b0; m_isrc = 1'b0; m_ready = 1'b0; m_flag = 1'b0; m_fault = 1'b0; m_irq = 1'b0;
        m_otrip = 4'd0; m_q1 = 1'b0; m_q2 = 1'b0;
        m_win.delete();
    endtask

    // Predict the outputs after the coming clock edge from the current inputs.
    task automatic model_edge();
        logic sync_used, prev_flag, rise, all_bad;
        m_edge++;
        sync_used = m_q2;
        m_q2 = m_q1;
        m_q1 = ovout_raw;
        prev_flag = m_flag;
        if (!en_req) begin
            m_mode = 0; m_ena = 1'b0; m_ready = 1'b0; m_flag = 1'b0;
            m_win.delete();
        end else if (m_mode == 0) begin
            m_mode = 1; m_ena = 1'b1; m_otrip = otrip_req; m_isrc = isrc_sel_req;
            m_ready = 1'b0; m_deadline = m_edge + SETTLE;
        end else if (m_mode == 1) begin
            m_otrip = otrip_req;
            if (isrc_sel_req != m_isrc) begin
                m_isrc = isrc_sel_req;
                m_deadline = m_edge + SETTLE;
            end else if (m_edge == m_deadline) begin
                m_mode = 2; m_ready = 1'b1;
            end
        end else if (isrc_sel_req != m_isrc) begin
            m_isrc = isrc_sel_req; m_otrip = otrip_req;
            m_mode = 1; m_ready = 1'b0; m_deadline = m_edge + SETTLE;
            m_win.delete();
        end else if (otrip_req != m_otrip) begin
            m_otrip = otrip_req;
            m_mode = 3; m_ready = 1'b0; m_deadline = m_edge + BLANK;
            m_win.delete();
        end else if (m_mode == 3) begin
            if (m_edge == m_deadline) begin
                m_mode = 2; m_ready = 1'b1;
            end
        end else begin
            m_win.push_back(sync_used != m_flag);
            if (m_win.size() >= DEB) begin
                all_bad = 1'b1;
                for (int i = m_win.size() - DEB; i < m_win.size(); i++) begin
                    if (!m_win[i]) all_bad = 1'b0;
                end
                if (all_bad) begin
                    m_flag = ~m_flag;
                    m_win.delete();
                end
            end
        end
        rise    = m_flag & ~prev_flag;
        m_irq   = rise;
        m_fault = rise | (m_fault & ~fault_clr);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    initial begin
        logic irq_seen;
        int   raw_left;

        resetb = 1'b0; en_req = 1'b0; otrip_req = 4'd0; isrc_sel_req = 1'b0;
        ovout_raw = 1'b0; fault_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 12'd0);
        resetb = 1'b1;

        //               en    ot     is    raw   clr  cyc   st    ena   ot     is    rdy   fl    fa    irq
        tbl.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0,  1, 2'd1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 63, 2'd1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0,  1, 2'd2, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd5, 1'b0, 1'b1, 1'b0,  9, 2'd2, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd5, 1'b0, 1'b1, 1'b0,  1, 2'd2, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 4'd5, 1'b0, 1'b1, 1'b0,  1, 2'd2, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0,  9, 2'd2, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0,  1, 2'd2, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'd9, 1'b0, 1'b0, 1'b0,  1, 2'd3, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'd9, 1'b0, 1'b1, 1'b0,  8, 2'd3, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b0,  1, 2'd3, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 15, 2'd3, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b0,  1, 2'd2, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b1,  1, 2'd2, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd3, 1'b0, 1'b1, 1'b0,  9, 2'd2, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd3, 1'b0, 1'b1, 1'b1,  1, 2'd2, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 4'd3, 1'b0, 1'b1, 1'b1,  1, 2'd2, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd7, 1'b1, 1'b1, 1'b0,  1, 2'd1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 63, 2'd1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd7, 1'b1, 1'b0, 1'b0,  1, 2'd2, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd7, 1'b1, 1'b0, 1'b0,  1, 2'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 10, 2'd1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd7, 1'b1, 1'b0, 1'b0,  1, 2'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd7, 1'b1, 1'b0, 1'b0,  1, 2'd1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 63, 2'd1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'd7, 1'b1, 1'b0, 1'b0,  1, 2'd2, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            en_req = tbl[i].en; otrip_req = tbl[i].ot; isrc_sel_req = tbl[i].is;
            ovout_raw = tbl[i].raw; fault_clr = tbl[i].clr;
            for (int c = 0; c < tbl[i].cyc; c++) tick();
            check($sformatf("row%0d", i), dut_vec(), tbl[i].exp);
        end

        // Glitches one cycle short of the debounce length must never reach ov_flag.
        irq_seen = 1'b0;
        for (int p = 0; p < 6; p++) begin
            ovout_raw = 1'b1;
            for (int c = 0; c < DEB - 1; c++) begin
                tick();
                irq_seen = irq_seen | ov_irq | ov_flag;
            end
            ovout_raw = 1'b0;
            tick();
            irq_seen = irq_seen | ov_irq | ov_flag;
        end
        repeat (3) tick();
        check("glitch_reject", {10'd0, irq_seen, ov_flag}, 12'd0);

        // Asynchronous reset in the middle of blanking.
        otrip_req = 4'd12;
        repeat (6) tick();
        check("pre_reset_blank", {10'd0, state}, 12'd3);
        #3;
        resetb = 1'b0;
        #1;
        check("async_reset", dut_vec(), 12'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_held", dut_vec(), 12'd0);
        resetb = 1'b1;

        // Randomized traffic against the reference model.
        raw_left = 0;
        for (int n = 0; n < 4000; n++) begin
            en_req = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 99) == 0) otrip_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 249) == 0) isrc_sel_req = ~isrc_sel_req;
            fault_clr = ($urandom_range(0, 15) == 0);
            if (raw_left == 0) begin
                ovout_raw = 1'($urandom_range(0, 1));
                raw_left  = $urandom_range(1, 20);
            end else begin
                raw_left--;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
